// File: rtl/zero_sync_tx.sv
// Serial frame transmitter: three-zero sync marker, a mark bit, then an LSB-first payload
// with bit stuffing so that three consecutive zeros appear only in the sync marker.
module zero_sync_tx #(
  parameter int WIDTH    = 16,
  parameter int SYNC_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SYNC, MARK, DATA} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    sync_cnt;
  logic [1:0]       zero_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_reg <= '0;
      idx       <= '0;
      sync_cnt  <= '0;
      zero_run  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out  <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            shift_reg <= data;
            out       <= 1'b0;
            busy      <= 1'b1;
            sync_cnt  <= CW'(1);
            state     <= SYNC;
          end
        end
        SYNC: begin
          if (sync_cnt == CW'(SYNC_LEN)) begin
            out   <= 1'b1;
            state <= MARK;
          end else begin
            out      <= 1'b0;
            sync_cnt <= sync_cnt + CW'(1);
          end
        end
        MARK: begin
          // The first payload bit already counts toward the zero run.
          out       <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          idx       <= CW'(1);
          zero_run  <= shift_reg[0] ? 2'd0 : 2'd1;
          state     <= DATA;
        end
        DATA: begin
          if (idx == CW'(WIDTH)) begin
            out   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (zero_run == 2'd2) begin
            // Stuffed 1 breaks the run; payload position does not advance.
            out      <= 1'b1;
            zero_run <= 2'd0;
          end else begin
            out       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            idx       <= idx + CW'(1);
            zero_run  <= shift_reg[0] ? 2'd0 : zero_run + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
